fp_compare_vec: RTL and testbench
=================================

// Module: fp_compare_vec
// PURPOSE
// - Pipelined, multi-lane FP32 compare/min/max unit for the FPU exec cluster; successor to the single-lane combinational compare.
// - Adds MIN/MAX, IEEE invalid-flag reporting, a lane mask, a tag passthrough, valid/ready handshakes, a fixed 2-stage pipeline and flush.
// - Sits between the FPU issue mux and the FPU writeback arbiter; one vector instruction = one beat.
// PARAMETERS
// - NUM_LANES  4  number of independent FP32 lanes per beat (>=1)
// - TAG_WIDTH  8  width of opaque tag carried alongside each beat (>=1)
// PORTS
// - clk           in   1                     clock
// - rst_n         in   1                     synchronous active-low reset
// - flush         in   1                     synchronous pipeline flush; drops all in-flight beats
// - in_valid      in   1                     input beat valid
// - in_ready      out  1                     unit can accept a beat this cycle
// - in_op         in   fpu_op_t              FPU_CMPEQ/CMPLT/CMPLE/MIN/MAX
// - in_lane_mask  in   NUM_LANES             1 = lane active
// - in_a          in   NUM_LANES*DATA_WIDTH  operand A; lane i = bits [i*32 +: 32]
// - in_b          in   NUM_LANES*DATA_WIDTH  operand B, same packing
// - in_tag        in   TAG_WIDTH             opaque tag
// - out_valid     out  1                     result beat valid
// - out_ready     in   1                     downstream accepts the result
// - out_result    out  NUM_LANES*DATA_WIDTH  per-lane result, same packing
// - out_invalid   out  NUM_LANES             per-lane IEEE invalid-operation flag
// - out_any_inv   out  1                     OR of out_invalid
// - out_tag       out  TAG_WIDTH             tag of the result beat
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): both stage valids, out_result, out_invalid, out_any_inv and out_tag are 0. in_ready=1 in the first cycle after reset.
// - Stage S1 registers classify (NaN/sNaN/zero/sign), magnitude-less and raw-equal per lane, plus op, mask and tag. S2 registers the final results.
// - Latency: exactly 2 cycles from input handshake to out_valid with no backpressure. Throughput: 1 beat/cycle.
// - Handshakes: a transfer occurs when valid && ready.
//   - adv2 = !s2_valid || out_ready
//   - adv1 = !s1_valid || adv2
//   - in_ready = adv1
//   - in_ready must not depend combinationally on in_valid.
// - Output stability: while out_valid && !out_ready, all out_* signals hold stable.
// - Simultaneous push and pop on a full pipe: both transfers occur and no bubble is inserted.
// - flush=1: s1_valid and s2_valid clear at that edge, and any input offered in the same cycle is dropped. in_ready may be 1 during flush.
// - Reset takes priority over flush. Reset mid-beat discards the beat and produces no partial output.
// - NaN classification:
//   - NaN  = exp==FF && mant!=0
//   - sNaN = NaN && mant[22]==0
//   - +0 and -0 compare equal.
// - CMPEQ: result {31'b0, a==b}; NaN on either side gives 0. Quiet compare: invalid only when either operand is sNaN.
// - CMPLT / CMPLE: result {31'b0, a<b} / {31'b0, a<=b}; NaN gives 0. Signalling compare: invalid when either operand is any NaN.
// - Ordering for CMPLT/CMPLE:
//   - Different signs: negative is less, except the ±0 pair.
//   - Same sign: magnitude order, inverted when negative.
// - MIN / MAX (IEEE minNum/maxNum):
//   - One operand qNaN: return the other operand.
//   - Both NaN, or either operand sNaN: return canonical qNaN 32'h7FC00000.
//   - -0 is treated as less than +0 (MIN(+0,-0) = 80000000, MAX = 00000000).
//   - Invalid is set iff either operand is sNaN.
// - Masked lane (in_lane_mask[i]=0): out_result lane = 0, out_invalid[i] = 0.
// - Unknown op: result 0, invalid 0.
// - out_any_inv is registered in S2, same cycle as out_invalid.
// - No internal state persists across beats other than the pipeline registers. No sticky flags; the CSR layer accumulates fflags.
// STRUCTURE
// - pkg_opengpu additions:
//   - FPU_MIN and FPU_MAX enumerators in fpu_op_t.
//   - FP_CANON_QNAN = 32'h7FC00000.
//   - fp_class_t struct {is_nan, is_snan, is_zero, sign}.
// - Sub-module fp_cmp_lane: a combinational per-lane core with
//   - inputs: classify, mag_less, equal
//   - outputs: result, invalid
//   - The core is split so the classify/mag part feeds S1 and the select part feeds S2. It is instantiated NUM_LANES times via generate.
// - Top level holds only the pipeline registers, the handshake logic and the lane generate loop.
// TESTING
// - Lane0 CMPLT a=3F800000(1.0) b=40000000(2.0), others masked -> after 2 cycles result lane0=1, lanes1-3=0, invalid=0.
// - CMPEQ a=00000000 b=80000000 -> 1. CMPLE a=7FA00000(sNaN) b=1.0 -> 0, invalid=1. CMPEQ a=7FC00000 b=1.0 -> 0, invalid=0.
// - MIN a=7FC00000 b=C0400000(-3.0) -> C0400000, inv=0. MAX a=7F800001 b=1.0 -> 7FC00000, inv=1. MIN +0/-0 -> 80000000.
// - Stream 6 beats with out_ready held 0 for cycles 3-6 -> in_ready=0 once 2 beats are held. Outputs are stable, and tags emerge in order 0..5 with no loss or duplication.
// - Full pipe with push and pop in the same cycle for 10 cycles -> 1 beat/cycle and no bubbles.
// - flush with 2 beats in flight plus 1 offered -> out_valid=0 the next cycle, and none of the 3 tags ever appear.
// - rst_n=0 mid-stream -> all outputs 0 the next cycle, and the next beat after release has latency 2.

Source files
------------

// File: rtl/fp_compare_vec_pkg.sv
// Shared types and helpers for the vector FP32 compare/min/max unit.
package fp_compare_vec_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        FPU_CMPEQ = 3'd0,
        FPU_CMPLT = 3'd1,
        FPU_CMPLE = 3'd2,
        FPU_MIN   = 3'd3,
        FPU_MAX   = 3'd4
    } fpu_op_t;

    localparam logic [31:0] FP_CANON_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_zero;
        logic sign;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        c.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        c.is_snan = c.is_nan && !x[22];
        c.is_zero = (x[30:0] == 31'd0);
        c.sign    = x[31];
        return c;
    endfunction

endpackage

// File: rtl/fp_compare_vec_lane.sv
// Per-lane combinational core: the classify half feeds stage 1, the select
// half consumes stage-1 registers and feeds stage 2.
module fp_cmp_lane
    import fp_compare_vec_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output fp_class_t   cls_a_o,
    output fp_class_t   cls_b_o,
    output logic        mag_less_o,
    output logic        equal_o,
    input  fpu_op_t     op_i,
    input  logic        active_i,
    input  fp_class_t   cls_a_i,
    input  fp_class_t   cls_b_i,
    input  logic        mag_less_i,
    input  logic        equal_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic [31:0] result_o,
    output logic        invalid_o
);

    assign cls_a_o    = fp_classify(a_i);
    assign cls_b_o    = fp_classify(b_i);
    assign mag_less_o = (a_i[30:0] < b_i[30:0]);
    assign equal_o    = (a_i == b_i);

    logic any_nan_s;
    logic any_snan_s;
    logic both_nan_s;
    logic both_zero_s;
    logic ord_lt_s;
    logic eq_s;
    logic lt_s;

    // Ordering primitives; ord_lt_s is a total order on non-NaN values with -0 < +0.
    always_comb begin
        any_nan_s   = cls_a_i.is_nan | cls_b_i.is_nan;
        any_snan_s  = cls_a_i.is_snan | cls_b_i.is_snan;
        both_nan_s  = cls_a_i.is_nan & cls_b_i.is_nan;
        both_zero_s = cls_a_i.is_zero & cls_b_i.is_zero;
        if (cls_a_i.sign != cls_b_i.sign) begin
            ord_lt_s = cls_a_i.sign;
        end else if (cls_a_i.sign) begin
            ord_lt_s = !mag_less_i && !equal_i;
        end else begin
            ord_lt_s = mag_less_i;
        end
        eq_s = !any_nan_s && (equal_i || both_zero_s);
        lt_s = !any_nan_s && !both_zero_s && ord_lt_s;
    end

    // Operation select; masked lanes and unknown ops produce all-zero results.
    always_comb begin
        result_o  = 32'd0;
        invalid_o = 1'b0;
        if (active_i) begin
            case (op_i)
                FPU_CMPEQ: begin
                    result_o  = {31'd0, eq_s};
                    invalid_o = any_snan_s;
                end
                FPU_CMPLT: begin
                    result_o  = {31'd0, lt_s};
                    invalid_o = any_nan_s;
                end
                FPU_CMPLE: begin
                    result_o  = {31'd0, lt_s | eq_s};
                    invalid_o = any_nan_s;
                end
                FPU_MIN, FPU_MAX: begin
                    invalid_o = any_snan_s;
                    if (any_snan_s || both_nan_s) begin
                        result_o = FP_CANON_QNAN;
                    end else if (cls_a_i.is_nan) begin
                        result_o = op_b_i;
                    end else if (cls_b_i.is_nan) begin
                        result_o = op_a_i;
                    end else if ((op_i == FPU_MIN) == ord_lt_s) begin
                        result_o = op_a_i;
                    end else begin
                        result_o = op_b_i;
                    end
                end
                default: begin
                    result_o  = 32'd0;
                    invalid_o = 1'b0;
                end
            endcase
        end else begin
            result_o  = 32'd0;
            invalid_o = 1'b0;
        end
    end

endmodule

// File: rtl/fp_compare_vec.sv
// Two-stage pipelined multi-lane FP32 compare/min/max with valid/ready
// handshakes, lane mask, tag passthrough and synchronous flush.
module fp_compare_vec
    import fp_compare_vec_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  fpu_op_t                         in_op,
    input  logic [NUM_LANES-1:0]            in_lane_mask,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_a,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_result,
    output logic [NUM_LANES-1:0]            out_invalid,
    output logic                            out_any_inv,
    output logic [TAG_WIDTH-1:0]            out_tag
);

    logic                            s1_valid_q, s1_valid_d;
    fpu_op_t                         s1_op_q;
    logic [NUM_LANES-1:0]            s1_mask_q;
    logic [TAG_WIDTH-1:0]            s1_tag_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] s1_a_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] s1_b_q;
    fp_class_t [NUM_LANES-1:0]       s1_cls_a_q;
    fp_class_t [NUM_LANES-1:0]       s1_cls_b_q;
    logic [NUM_LANES-1:0]            s1_mag_less_q;
    logic [NUM_LANES-1:0]            s1_equal_q;

    logic                            s2_valid_q, s2_valid_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] s2_result_q;
    logic [NUM_LANES-1:0]            s2_invalid_q;
    logic                            s2_any_inv_q;
    logic [TAG_WIDTH-1:0]            s2_tag_q;

    fp_class_t [NUM_LANES-1:0]       cls_a_s;
    fp_class_t [NUM_LANES-1:0]       cls_b_s;
    logic [NUM_LANES-1:0]            mag_less_s;
    logic [NUM_LANES-1:0]            equal_s;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_res_s;
    logic [NUM_LANES-1:0]            lane_inv_s;

    logic adv1_s;
    logic adv2_s;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        fp_cmp_lane u_lane (
            .a_i        (in_a[gi*DATA_WIDTH +: DATA_WIDTH]),
            .b_i        (in_b[gi*DATA_WIDTH +: DATA_WIDTH]),
            .cls_a_o    (cls_a_s[gi]),
            .cls_b_o    (cls_b_s[gi]),
            .mag_less_o (mag_less_s[gi]),
            .equal_o    (equal_s[gi]),
            .op_i       (s1_op_q),
            .active_i   (s1_mask_q[gi]),
            .cls_a_i    (s1_cls_a_q[gi]),
            .cls_b_i    (s1_cls_b_q[gi]),
            .mag_less_i (s1_mag_less_q[gi]),
            .equal_i    (s1_equal_q[gi]),
            .op_a_i     (s1_a_q[gi*DATA_WIDTH +: DATA_WIDTH]),
            .op_b_i     (s1_b_q[gi*DATA_WIDTH +: DATA_WIDTH]),
            .result_o   (lane_res_s[gi*DATA_WIDTH +: DATA_WIDTH]),
            .invalid_o  (lane_inv_s[gi])
        );
    end

    // Handshake: each stage advances when its downstream slot is free or draining.
    always_comb begin
        adv2_s = !s2_valid_q || out_ready;
        adv1_s = !s1_valid_q || adv2_s;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            s1_valid_d = adv1_s ? in_valid : s1_valid_q;
            s2_valid_d = adv2_s ? s1_valid_q : s2_valid_q;
        end
    end

    // Pipeline registers; data only moves with its valid so held outputs stay stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_op_q       <= FPU_CMPEQ;
            s1_mask_q     <= '0;
            s1_tag_q      <= '0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_cls_a_q    <= '0;
            s1_cls_b_q    <= '0;
            s1_mag_less_q <= '0;
            s1_equal_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_result_q   <= '0;
            s2_invalid_q  <= '0;
            s2_any_inv_q  <= 1'b0;
            s2_tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (adv1_s && in_valid && !flush) begin
                s1_op_q       <= in_op;
                s1_mask_q     <= in_lane_mask;
                s1_tag_q      <= in_tag;
                s1_a_q        <= in_a;
                s1_b_q        <= in_b;
                s1_cls_a_q    <= cls_a_s;
                s1_cls_b_q    <= cls_b_s;
                s1_mag_less_q <= mag_less_s;
                s1_equal_q    <= equal_s;
            end
            if (adv2_s && s1_valid_q && !flush) begin
                s2_result_q  <= lane_res_s;
                s2_invalid_q <= lane_inv_s;
                s2_any_inv_q <= |lane_inv_s;
                s2_tag_q     <= s1_tag_q;
            end
        end
    end

    assign in_ready    = adv1_s;
    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_invalid = s2_invalid_q;
    assign out_any_inv = s2_any_inv_q;
    assign out_tag     = s2_tag_q;

endmodule

// File: tb/tb_fp_compare_vec.sv
// Scoreboard bench for fp_compare_vec: directed vectors push expectations,
// an independent monitor pops and compares on every output handshake.
module tb_fp_compare_vec;
    import fp_compare_vec_pkg::*;

    localparam int NL = 4;
    localparam int TW = 8;
    localparam int VW = NL * 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    fpu_op_t       in_op = FPU_CMPEQ;
    logic [NL-1:0] in_lane_mask = '0;
    logic [VW-1:0] in_a = '0;
    logic [VW-1:0] in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out_result;
    logic [NL-1:0] out_invalid;
    logic          out_any_inv;
    logic [TW-1:0] out_tag;

    typedef struct {
        logic [TW-1:0] tag;
        logic [VW-1:0] res;
        logic [NL-1:0] inv;
        bit            lat_chk;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    bit   banned[256];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   n_push = 0;
    bit   saw_stall = 1'b0;

    fp_compare_vec #(.NUM_LANES(NL), .TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_lane_mask (in_lane_mask),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_invalid  (out_invalid),
        .out_any_inv  (out_any_inv),
        .out_tag      (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: output stability while stalled, and scoreboard pop on each transfer.
    initial begin : monitor
        logic          hold;
        logic [VW-1:0] h_res;
        logic [NL-1:0] h_inv;
        logic [TW-1:0] h_tag;
        exp_t          e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_valid", VW'(out_valid), VW'(1));
                chk("hold_result", out_result, h_res);
                chk("hold_invalid", VW'(out_invalid), VW'(h_inv));
                chk("hold_tag", VW'(out_tag), VW'(h_tag));
            end
            hold  = out_valid && !out_ready && !flush && rst_n;
            h_res = out_result;
            h_inv = out_invalid;
            h_tag = out_tag;
            if (out_valid && out_ready && !flush && rst_n) begin
                n_out++;
                if (banned[out_tag]) begin
                    checks++;
                    errors++;
                    $display("FAIL dropped_tag: got tag %h which must never appear", out_tag);
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tag %h with empty scoreboard", out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("tag", VW'(out_tag), VW'(e.tag));
                    chk("result", out_result, e.res);
                    chk("invalid", VW'(out_invalid), VW'(e.inv));
                    chk("any_inv", VW'(out_any_inv), VW'(|e.inv));
                    if (e.lat_chk) chk("latency", VW'(cyc - e.cyc), VW'(2));
                end
            end
        end
    end

    // Offer one beat starting at posedge+1; expectation is queued just before the accepting edge.
    task automatic send(input fpu_op_t op, input logic [NL-1:0] mask, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [TW-1:0] tag,
                        input logic [VW-1:0] res, input logic [NL-1:0] inv, input bit lat);
        exp_t e;
        bit   done;
        done         = 1'b0;
        in_valid     = 1'b1;
        in_op        = op;
        in_lane_mask = mask;
        in_a         = a;
        in_b         = b;
        in_tag       = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.tag = tag; e.res = res; e.inv = inv; e.lat_chk = lat; e.cyc = cyc;
                sb.push_back(e);
                n_push++;
                done = 1'b1;
            end else begin
                saw_stall = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tag %h never accepted, required within 50 cycles", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", VW'(sb.size()), VW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] mx;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        chk("rst_result", out_result, VW'(0));
        chk("rst_invalid", VW'(out_invalid), VW'(0));
        chk("rst_any_inv", VW'(out_any_inv), VW'(0));
        chk("rst_tag", VW'(out_tag), VW'(0));
        chk("rst_in_ready", VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;

        // Directed vectors, lanes written {l3, l2, l1, l0}.
        send(FPU_CMPLT, 4'b0001,
             {32'h7F800001, 32'h7F800001, 32'h7F800001, 32'h3F800000},
             {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000},
             8'h10, {32'd0, 32'd0, 32'd0, 32'd1}, 4'b0000, 1'b1);
        send(FPU_CMPEQ, 4'b1111,
             {32'h3F800000, 32'h7FA00000, 32'h7FC00000, 32'h00000000},
             {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h80000000},
             8'h11, {32'd1, 32'd0, 32'd0, 32'd1}, 4'b0100, 1'b1);
        send(FPU_CMPLE, 4'b1111,
             {32'h80000000, 32'hC0400000, 32'h7FC00000, 32'h7FA00000},
             {32'h00000000, 32'hBF800000, 32'h3F800000, 32'h3F800000},
             8'h12, {32'd1, 32'd1, 32'd0, 32'd0}, 4'b0011, 1'b1);
        send(FPU_CMPLT, 4'b1111,
             {32'h40000000, 32'hC0400000, 32'hBF800000, 32'h00000000},
             {32'h40000000, 32'h3F800000, 32'hC0400000, 32'h80000000},
             8'h13, {32'd0, 32'd1, 32'd0, 32'd0}, 4'b0000, 1'b1);
        send(FPU_MIN, 4'b1111,
             {32'h3F800000, 32'h7FC00000, 32'h00000000, 32'h7FC00000},
             {32'h7F800001, 32'hFFC00001, 32'h80000000, 32'hC0400000},
             8'h14, {32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'hC0400000}, 4'b1000, 1'b1);
        send(FPU_MAX, 4'b1111,
             {32'h3F800000, 32'hC0400000, 32'h00000000, 32'h7F800001},
             {32'h7FC00000, 32'hBF800000, 32'h80000000, 32'h3F800000},
             8'h15, {32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7FC00000}, 4'b0001, 1'b1);
        send(FPU_MIN, 4'b0101,
             {32'h7F800001, 32'hFF800000, 32'h7F800001, 32'h40000000},
             {32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000},
             8'h16, {32'd0, 32'hFF800000, 32'd0, 32'h3F800000}, 4'b0000, 1'b1);
        send(fpu_op_t'(3'd7), 4'b1111,
             {4{32'h7F800001}}, {4{32'h3F800000}},
             8'h17, {VW{1'b0}}, 4'b0000, 1'b1);
        drain();

        // Full pipe, push and pop every cycle: latency stays 2 and in_ready never drops.
        saw_stall = 1'b0;
        for (int k = 0; k < 12; k++) begin
            mx = (k > 6) ? 32'(k) : 32'd6;
            send(FPU_MAX, 4'b0001, {96'd0, 32'(k)}, {96'd0, 32'd6},
                 8'(8'h20 + k), {96'd0, mx}, 4'b0000, 1'b1);
        end
        chk("throughput_no_stall", VW'(saw_stall), VW'(0));
        drain();

        // Backpressure: out_ready low for cycles 3-6 of a 6-beat stream.
        saw_stall = 1'b0;
        fork
            begin
                out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 6; k++)
                    send(FPU_CMPEQ, 4'b0001, {96'd0, 32'(k)}, {96'd0, 32'd2},
                         8'(k), {96'd0, 31'd0, (k == 2) ? 1'b1 : 1'b0}, 4'b0000, 1'b0);
            end
        join
        chk("backpressure_stall", VW'(saw_stall), VW'(1));
        drain();

        // Flush with two beats in flight and a third offered.
        out_ready = 1'b0;
        banned[8'hF0] = 1'b1;
        banned[8'hF1] = 1'b1;
        banned[8'hF2] = 1'b1;
        in_valid = 1'b1; in_op = FPU_MAX; in_lane_mask = 4'b1111;
        in_a = {4{32'h3F800000}}; in_b = {4{32'h40000000}};
        in_tag = 8'hF0;
        @(posedge clk); #1;
        in_tag = 8'hF1;
        @(posedge clk); #1;
        in_tag = 8'hF2;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", VW'(out_valid), VW'(0));
        @(posedge clk); #1;
        send(FPU_CMPLT, 4'b0001, {96'd0, 32'h3F800000}, {96'd0, 32'h40000000},
             8'h30, {96'd0, 32'd1}, 4'b0000, 1'b1);
        drain();

        // Reset mid-stream with two beats held inside the pipe.
        out_ready = 1'b0;
        banned[8'hA0] = 1'b1;
        banned[8'hA1] = 1'b1;
        in_valid = 1'b1; in_op = FPU_MAX; in_lane_mask = 4'b1111;
        in_a = {4{32'h3F800000}}; in_b = {4{32'h7F800001}};
        in_tag = 8'hA0;
        @(posedge clk); #1;
        in_tag = 8'hA1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", VW'(out_valid), VW'(0));
        chk("midrst_result", out_result, VW'(0));
        chk("midrst_invalid", VW'(out_invalid), VW'(0));
        chk("midrst_any_inv", VW'(out_any_inv), VW'(0));
        chk("midrst_tag", VW'(out_tag), VW'(0));
        chk("midrst_in_ready", VW'(in_ready), VW'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(FPU_CMPLE, 4'b0010, {32'd0, 32'd0, 32'hC0400000, 32'd0},
             {32'd0, 32'd0, 32'hC0400000, 32'd0},
             8'h40, {32'd0, 32'd0, 32'd1, 32'd0}, 4'b0000, 1'b1);
        drain();

        chk("output_count", VW'(n_out), VW'(n_push));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
